// File: rtl/riscv_pkg.sv
// riscv_pkg: shared encodings for the multicycle RV32I control unit
package riscv_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } statetype;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RS_ALUOUT    = 2'b00;
    localparam logic [1:0] RS_DATA      = 2'b01;
    localparam logic [1:0] RS_ALURESULT = 2'b10;

    localparam logic [1:0] SA_PC    = 2'b00;
    localparam logic [1:0] SA_OLDPC = 2'b01;
    localparam logic [1:0] SA_RS1   = 2'b10;

    localparam logic [1:0] SB_RS2  = 2'b00;
    localparam logic [1:0] SB_IMM  = 2'b01;
    localparam logic [1:0] SB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_controller_aludec.sv
// aludec: maps the FSM's alu_op and instruction function bits to an ALU operation
module aludec
    import riscv_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    logic r_sub;

    assign r_sub = op5 & funct7b5;

    // Fixed add/sub for address and compare steps, funct3 decode for arithmetic
    always_comb begin
        alu_control = (alu_op == ALUOP_SUB)   ? ALU_SUB :
                      (alu_op != ALUOP_FUNCT) ? ALU_ADD :
                      (funct3 == 3'b000)      ? (r_sub ? ALU_SUB : ALU_ADD) :
                      (funct3 == 3'b010)      ? ALU_SLT :
                      (funct3 == 3'b110)      ? ALU_OR  :
                      (funct3 == 3'b111)      ? ALU_AND : ALU_ADD;
    end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore main FSM plus ALU/immediate decode for the multicycle RV32I core
module multicycle_controller
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       reg_write,
    output logic [1:0] imm_src,
    output logic [2:0] alu_control,
    output logic       illegal_op
);

    statetype   state_q, state_d;
    logic [1:0] alu_op;
    logic       pc_update, branch, mem_write_s, ir_write_s, reg_write_s;

    // State register; reset returns to Fetch immediately so no partial write survives
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_FETCH;
        else          state_q <= state_d;
    end

    // Next-state sequencing through fetch, decode and the per-class execute steps
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = S_DECODE;
            S_DECODE:   state_d = (op == OP_LW || op == OP_SW) ? S_MEMADR   :
                                  (op == OP_R)                 ? S_EXECUTER :
                                  (op == OP_I)                 ? S_EXECUTEI :
                                  (op == OP_JAL)               ? S_JAL      :
                                  (op == OP_BEQ)               ? S_BEQ      : S_FETCH;
            S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_JAL:      state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // Moore output decode; unlisted controls stay 0 and selects stay 00
    always_comb begin
        adr_src     = 1'b0;
        mem_write_s = 1'b0;
        ir_write_s  = 1'b0;
        result_src  = RS_ALUOUT;
        alu_src_a   = SA_PC;
        alu_src_b   = SB_RS2;
        reg_write_s = 1'b0;
        alu_op      = ALUOP_ADD;
        pc_update   = 1'b0;
        branch      = 1'b0;
        illegal_op  = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_write_s = 1'b1;
                pc_update  = 1'b1;
                alu_src_b  = SB_FOUR;
                result_src = RS_ALURESULT;
            end
            S_DECODE: begin
                alu_src_a  = SA_OLDPC;
                alu_src_b  = SB_IMM;
                illegal_op = !(op == OP_LW || op == OP_SW || op == OP_R ||
                               op == OP_I || op == OP_JAL || op == OP_BEQ);
            end
            S_MEMADR: begin
                alu_src_a = SA_RS1;
                alu_src_b = SB_IMM;
            end
            S_MEMREAD: adr_src = 1'b1;
            S_MEMWB: begin
                result_src  = RS_DATA;
                reg_write_s = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src     = 1'b1;
                mem_write_s = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a = SA_RS1;
                alu_op    = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                alu_src_a = SA_RS1;
                alu_src_b = SB_IMM;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: reg_write_s = 1'b1;
            S_JAL: begin
                alu_src_a = SA_OLDPC;
                alu_src_b = SB_FOUR;
                pc_update = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = SA_RS1;
                alu_op    = ALUOP_SUB;
                branch    = 1'b1;
            end
            default: ;
        endcase
    end

    // Immediate format follows the opcode alone
    always_comb begin
        imm_src = (op == OP_SW)  ? IMM_S :
                  (op == OP_BEQ) ? IMM_B :
                  (op == OP_JAL) ? IMM_J : IMM_I;
    end

    // Write enables are held off for the whole reset, even though state shows Fetch
    assign pc_write  = reset_n & ((zero & branch) | pc_update);
    assign ir_write  = reset_n & ir_write_s;
    assign mem_write = reset_n & mem_write_s;
    assign reg_write = reset_n & reg_write_s;

    aludec u_aludec (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .op5         (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (alu_control)
    );

endmodule
